// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, NMI id,
// default vector base and the vector-address helper.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [3:0]  NMI_ID       = 4'd14;
  localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;

  // Two-byte vector table entries; id 14 lands on 16'hFFFC, 16'hFFFE stays reserved.
  function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [3:0] id);
    return base + {11'd0, id, 1'b0};
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Handshake between the interrupt controller (slave) and the instruction
// decoder / status register side (master).
interface irq_ctrl_if #(parameter int NSRC = 14) ();

  logic            GIE;
  logic            IRQ_ack;
  logic            RETI;
  logic            ie_wr;
  logic [NSRC-1:0] ie_din;
  logic [NSRC-1:0] ie_out;
  logic            IRQ_req;
  logic [15:0]     IRQ_vec;
  logic [3:0]      IRQ_id;

  modport master (
    output GIE, IRQ_ack, RETI, ie_wr, ie_din,
    input  ie_out, IRQ_req, IRQ_vec, IRQ_id
  );

  modport slave (
    input  GIE, IRQ_ack, RETI, ie_wr, ie_din,
    output ie_out, IRQ_req, IRQ_vec, IRQ_id
  );

endinterface

// File: rtl/irq_ctrl_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector for one
// asynchronous interrupt line.
module irq_ctrl_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_p
);

  logic meta_r;
  logic sync_r;
  logic hist_r;

  // Synchronizer chain plus one history flop; history resets low so a line
  // already high at reset release still yields an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      hist_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      hist_r <= sync_r;
    end
  end

  assign edge_p = sync_r & ~hist_r;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: NSRC maskable sources plus NMI, pending latches,
// fixed priority selection and a request/service handshake with instr_dec.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC     = 14,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            nmi_in,
  irq_ctrl_if.slave       bus
);

  // Bit NSRC of every source-wide vector is the NMI.
  logic [NSRC:0]   src_all_s;
  logic [NSRC:0]   edge_s;
  logic [NSRC:0]   clr_s;
  logic [NSRC:0]   pend_next_s;
  logic [NSRC-1:0] elig_s;
  logic [3:0]      sel_id_s;
  logic            any_elig_s;
  logic            ack_s;
  logic            cur_nmi_s;
  logic            keep_s;

  irq_state_t      state_r;
  logic [NSRC:0]   pend_r;
  logic [NSRC-1:0] ie_r;
  logic            req_r;
  logic [3:0]      id_r;
  logic [15:0]     vec_r;

  assign src_all_s = {nmi_in, irq_src};

  for (genvar g = 0; g <= NSRC; g++) begin : g_sync
    irq_ctrl_sync_edge u_sync_edge (
      .clk    (clk),
      .rst_n  (rst),
      .din    (src_all_s[g]),
      .edge_p (edge_s[g])
    );
  end

  // Priority select (NMI, then highest maskable id), ack-driven pending clear
  // and the eligibility check that keeps a maskable request alive.
  always_comb begin
    elig_s      = pend_r[NSRC-1:0] & ie_r & {NSRC{bus.GIE}};
    sel_id_s    = 4'd0;
    keep_s      = 1'b0;
    clr_s       = '0;
    ack_s       = (state_r == ST_REQ) && bus.IRQ_ack;
    cur_nmi_s   = (id_r == NMI_ID);
    for (int i = 0; i < NSRC; i++) begin
      sel_id_s = elig_s[i] ? 4'(i) : sel_id_s;
      keep_s   = keep_s | ((id_r == 4'(i)) & ie_r[i] & bus.GIE);
      clr_s[i] = ack_s & (id_r == 4'(i));
    end
    clr_s[NSRC] = ack_s & cur_nmi_s;
    if (pend_r[NSRC]) begin
      sel_id_s = NMI_ID;
    end else begin
      sel_id_s = sel_id_s;
    end
    any_elig_s  = pend_r[NSRC] | (|elig_s);
    // New edges are OR-ed in after the clear so a coincident edge survives.
    pend_next_s = (pend_r & ~clr_s) | edge_s;
  end

  // Request/service FSM with pending, enable and all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      pend_r  <= '0;
      ie_r    <= '0;
      req_r   <= 1'b0;
      id_r    <= 4'd0;
      vec_r   <= VEC_BASE;
    end else begin
      pend_r <= pend_next_s;
      if (bus.ie_wr) begin
        ie_r <= bus.ie_din;
      end
      case (state_r)
        ST_IDLE: begin
          if (any_elig_s) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            id_r    <= sel_id_s;
            vec_r   <= vec_addr(VEC_BASE, sel_id_s);
          end
        end
        ST_REQ: begin
          if (bus.IRQ_ack) begin
            state_r <= ST_SERVICE;
            req_r   <= 1'b0;
          end else if (!cur_nmi_s && !keep_s) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (bus.RETI) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ie_out  = ie_r;
  assign bus.IRQ_req = req_r;
  assign bus.IRQ_id  = id_r;
  assign bus.IRQ_vec = vec_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus pushes expected requests into a
// queue, a monitor compares each rising IRQ_req against the queue head.
module tb_irq_ctrl;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] vec;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [13:0] irq_src;
  logic        nmi_in;
  exp_t        exp_q[$];
  int          compared;
  int          mismatched;
  logic        mon_prev;

  irq_ctrl_if #(.NSRC(14)) bus ();

  irq_ctrl #(.NSRC(14), .VEC_BASE(16'hFFE0)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .nmi_in  (nmi_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [3:0] id, input logic [15:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic wait_req(input string name, input int budget);
    for (int i = 0; i < budget && !bus.IRQ_req; i++) tick(1);
    check(name, 16'(bus.IRQ_req), 16'd1);
  endtask

  task automatic pulse_src(input int b);
    irq_src[b] = 1'b1;
    tick(1);
    irq_src[b] = 1'b0;
  endtask

  task automatic do_ack(input string name);
    bus.IRQ_ack = 1'b1;
    tick(1);
    bus.IRQ_ack = 1'b0;
    check(name, 16'(bus.IRQ_req), 16'd0);
  endtask

  task automatic do_reti();
    bus.RETI = 1'b1;
    tick(1);
    bus.RETI = 1'b0;
  endtask

  task automatic write_ie(input logic [13:0] v);
    bus.ie_wr  = 1'b1;
    bus.ie_din = v;
    tick(1);
    bus.ie_wr  = 1'b0;
  endtask

  // Scoreboard monitor: every new request must match the oldest expectation.
  initial begin
    exp_t e;
    mon_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_prev = 1'b0;
      end else begin
        if (bus.IRQ_req && !mon_prev) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL sb_unexpected: got id=%0d vec=%h, expected no request",
                     bus.IRQ_id, bus.IRQ_vec);
          end else begin
            e = exp_q.pop_front();
            if (bus.IRQ_id !== e.id || bus.IRQ_vec !== e.vec) begin
              mismatched++;
              $display("FAIL sb_req: got id=%0d vec=%h, expected id=%0d vec=%h",
                       bus.IRQ_id, bus.IRQ_vec, e.id, e.vec);
            end
          end
        end
        mon_prev = bus.IRQ_req;
      end
    end
  end

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b0;
    irq_src     = 14'd0;
    nmi_in      = 1'b0;
    bus.GIE     = 1'b0;
    bus.IRQ_ack = 1'b0;
    bus.RETI    = 1'b0;
    bus.ie_wr   = 1'b0;
    bus.ie_din  = 14'd0;
    #12;
    check("rst_req", 16'(bus.IRQ_req), 16'd0);
    check("rst_id",  16'(bus.IRQ_id),  16'd0);
    check("rst_vec", bus.IRQ_vec,      16'hFFE0);
    check("rst_ie",  16'(bus.ie_out),  16'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Single source, exact latency, handshake and hold outside REQ.
    write_ie(14'h0020);
    check("ie_out", 16'(bus.ie_out), 16'h0020);
    bus.GIE = 1'b1;
    expect_req(4'd5, 16'hFFEA);
    pulse_src(5);
    tick(2);
    check("lat_early", 16'(bus.IRQ_req), 16'd0);
    tick(1);
    check("lat_4th", 16'(bus.IRQ_req), 16'd1);
    do_ack("ack_drop5");
    tick(3);
    check("svc_quiet", 16'(bus.IRQ_req), 16'd0);
    do_reti();
    tick(3);
    check("idle_quiet", 16'(bus.IRQ_req), 16'd0);
    check("hold_id",  16'(bus.IRQ_id), 16'd5);
    check("hold_vec", bus.IRQ_vec,     16'hFFEA);

    // Simultaneous sources: higher id first, the other after RETI.
    write_ie(14'h3FFF);
    expect_req(4'd9, 16'hFFF2);
    expect_req(4'd2, 16'hFFE4);
    irq_src[2] = 1'b1;
    irq_src[9] = 1'b1;
    tick(1);
    irq_src = 14'd0;
    wait_req("req9", 8);
    do_ack("ack_drop9");
    tick(2);
    do_reti();
    wait_req("req2", 8);
    do_ack("ack_drop2");
    do_reti();

    // NMI ignores GIE and is never withdrawn; masked source waits for GIE.
    bus.GIE = 1'b0;
    pulse_src(3);
    tick(5);
    check("gie_block", 16'(bus.IRQ_req), 16'd0);
    expect_req(4'd14, 16'hFFFC);
    nmi_in = 1'b1;
    tick(1);
    nmi_in = 1'b0;
    wait_req("req_nmi", 8);
    tick(3);
    check("nmi_hold", 16'(bus.IRQ_req), 16'd1);
    do_ack("ack_drop_nmi");
    do_reti();
    tick(3);
    check("nmi_no_repeat", 16'(bus.IRQ_req), 16'd0);
    expect_req(4'd3, 16'hFFE6);
    bus.GIE = 1'b1;
    wait_req("req3", 4);
    do_ack("ack_drop3");
    do_reti();

    // Withdrawal on GIE drop keeps pending; stray ack in IDLE is ignored.
    expect_req(4'd4, 16'hFFE8);
    pulse_src(4);
    wait_req("req4", 8);
    bus.GIE = 1'b0;
    tick(1);
    check("withdraw", 16'(bus.IRQ_req), 16'd0);
    bus.IRQ_ack = 1'b1;
    tick(1);
    bus.IRQ_ack = 1'b0;
    tick(1);
    check("withdraw_stay", 16'(bus.IRQ_req), 16'd0);
    expect_req(4'd4, 16'hFFE8);
    bus.GIE = 1'b1;
    wait_req("rereq4", 4);
    do_ack("ack_drop4");
    do_reti();

    // New edge coincident with the ack edge survives the clear.
    expect_req(4'd7, 16'hFFEE);
    pulse_src(7);
    wait_req("req7", 8);
    expect_req(4'd7, 16'hFFEE);
    irq_src[7] = 1'b1;
    tick(1);
    irq_src[7] = 1'b0;
    tick(1);
    do_ack("ack_drop7");
    tick(4);
    check("svc_pend_quiet", 16'(bus.IRQ_req), 16'd0);
    do_reti();
    wait_req("rereq7", 4);
    do_ack("ack_drop7b");
    do_reti();

    // Unaligned reset mid-SERVICE with another source pending.
    expect_req(4'd1, 16'hFFE2);
    pulse_src(1);
    wait_req("req1", 8);
    do_ack("ack_drop1");
    pulse_src(6);
    tick(3);
    #4;
    rst = 1'b0;
    #1;
    check("arst_req", 16'(bus.IRQ_req), 16'd0);
    check("arst_id",  16'(bus.IRQ_id),  16'd0);
    check("arst_vec", bus.IRQ_vec,      16'hFFE0);
    check("arst_ie",  16'(bus.ie_out),  16'd0);
    #6;
    rst = 1'b1;
    tick(1);
    write_ie(14'h3FFF);
    tick(6);
    check("post_reset_idle", 16'(bus.IRQ_req), 16'd0);

    // Source already high at reset release counts as an edge.
    rst = 1'b0;
    irq_src[10] = 1'b1;
    tick(2);
    rst = 1'b1;
    write_ie(14'h3FFF);
    expect_req(4'd10, 16'hFFF4);
    wait_req("req10", 8);
    do_ack("ack_drop10");
    irq_src[10] = 1'b0;
    do_reti();
    tick(4);

    check("sb_drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 14: number of maskable interrupt sources, ids 0..NSRC-1; legal range 1..14.
REQ-002 Parameter VEC_BASE, default 16'hFFE0: vector address of id 0.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 irq_src  input  NSRC  maskable interrupt sources, asynchronous to clk.
REQ-006 nmi_in  input  1  non-maskable interrupt source, asynchronous to clk.
REQ-007 GIE  input  1  global interrupt enable, taken from status register bit 3.
REQ-008 IRQ_ack  input  1  one-cycle pulse from instr_dec accepting the presented interrupt.
REQ-009 RETI  input  1  one-cycle pulse from instr_dec on completion of RETI.
REQ-010 ie_wr  input  1  write strobe for the enable register.
REQ-011 ie_din  input  NSRC  enable register write data.
REQ-012 ie_out  output  NSRC  current enable register.
REQ-013 IRQ_req  output  1  interrupt request to instr_dec.
REQ-014 IRQ_vec  output  16  vector-table address of the presented interrupt.
REQ-015 IRQ_id  output  4  id of the presented interrupt; NMI = 14.

Function
REQ-016 Each source passes through a 2-flop synchronizer plus a rising-edge detector; a detected edge sets that source's pending bit.
REQ-017 Latency: source high before edge E0 -> pending set at E2 -> IRQ_req high after E3, given IDLE and eligibility.
REQ-018 A maskable source is eligible when its pending bit, its ie bit and GIE are all 1; a pending NMI is eligible regardless of GIE and ie.
REQ-019 Priority: NMI highest, then highest maskable id.
REQ-020 IRQ_vec = VEC_BASE + 2*id, giving NMI 16'hFFFC; the reset vector 16'hFFFE is never produced.
REQ-021 FSM states: IDLE, REQ, SERVICE.
REQ-022 IDLE -> REQ on the first edge with any eligible source; IRQ_id and IRQ_vec latch at that edge.
REQ-023 In REQ: IRQ_req=1; IRQ_id and IRQ_vec stay frozen even if a higher-priority source becomes pending.
REQ-024 REQ -> SERVICE on IRQ_ack; the presented source's pending bit clears at the same edge; IRQ_req drops the next cycle.
REQ-025 REQ -> IDLE with no ack if a maskable request loses eligibility (GIE=0 or ie bit cleared); pending is retained.
REQ-026 An NMI request is never withdrawn.
REQ-027 SERVICE -> IDLE on RETI; no request is raised while in SERVICE, but edges still set pending bits.
REQ-028 IRQ_ack outside REQ and RETI outside SERVICE are ignored.
REQ-029 If a pending bit sees set and clear at the same edge, set wins.
REQ-030 An edge arriving while the bit is already pending is merged: one service only.
REQ-031 ie_wr updates ie_out at the next edge; ie_out is readable every cycle.
REQ-032 IRQ_id and IRQ_vec hold their last values outside REQ.

Reset
REQ-033 While rst=0, regardless of clk: FSM=IDLE, all pending bits, synchronizer and edge flops = 0, ie_out=0, IRQ_req=0, IRQ_id=0, IRQ_vec=VEC_BASE.
REQ-034 A source already high at reset release is treated as a rising edge (edge-detector history = 0).
REQ-035 Reset asserted in REQ or SERVICE aborts the sequence; no ack is required afterwards.

Structure
REQ-036 The shared header irq_defs.vh holds the FSM state encodings, NMI_ID=14 and VEC_BASE default; pipeline and instr_dec include it.
REQ-037 One sub-module, sync_edge: 2-flop synchronizer plus rising-edge pulse, instantiated NSRC+1 times.
REQ-038 The priority encoder is combinational inside irq_ctrl and has no other sub-modules.

Verification
REQ-039 ie=14'h0020, GIE=1, pulse irq_src[5] -> IRQ_req after the 4th edge, IRQ_id=5, IRQ_vec=16'hFFEA; ack -> SERVICE; RETI -> IDLE.
REQ-040 ie=all 1s, irq_src[2] and [9] rise together -> id 9 (16'hFFF2) served first; after RETI, id 2 (16'hFFE4) is requested.
REQ-041 GIE=0, nmi_in rising edge -> IRQ_req, IRQ_id=14, IRQ_vec=16'hFFFC; a pending irq_src[3] is not requested.
REQ-042 In REQ for id 4, drop GIE -> IRQ_req=0 next cycle, pending[4] still 1; restore GIE -> re-request of id 4.
REQ-043 Assert rst=0 mid-SERVICE, unaligned to clk -> all outputs at reset values immediately; after release with sources low, IRQ_req stays 0.
REQ-044 Edge on irq_src[7] at the same edge as IRQ_ack for id 7 -> pending[7] stays 1 and is re-requested after RETI.
